// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver:
// FSM state encoding and error-flag bit positions.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int ERR_FRAMING = 0;
    localparam int ERR_PARITY  = 1;
    localparam int ERR_W       = 2;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO holding received frames (data + error flags).
// Pointers carry one extra wrap bit so full and empty are distinct.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wp == rp);
    assign level   = wp - rp;
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rp[AW-1:0]];

    // Storage and pointer update; a push into a full FIFO only
    // lands when the head is being popped in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wp[AW-1:0]] <= push_data;
                wp              <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver with a small frame FIFO, overrun flag and RTS.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int DIV_W        = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rxd,
    input  logic [DIV_W-1:0]              divider,
    input  logic                          parity_odd,
    output logic                          uart_rts,
    input  logic                          uart_rx_read,
    output logic                          uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0]       uart_rx_data,
    output logic [ERR_W-1:0]              uart_rx_error,
    output logic                          uart_rx_overrun,
    input  logic                          overrun_clear,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(PAYLOAD_BITS);
    localparam int EW = PAYLOAD_BITS + ERR_W;

    rx_state_t               state;
    logic [2:0]              sync_q;
    logic                    rxd_s;
    logic                    rxd_prev;
    logic [DIV_W-1:0]        div_q;
    logic [DIV_W-1:0]        cnt;
    logic [BW-1:0]           bit_idx;
    logic                    stop_idx;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic                    ferr;
    logic                    perr;
    logic                    push_q;
    logic                    mid;
    logic                    last;
    logic [ERR_W-1:0]        flags;
    logic [EW-1:0]           push_data;
    logic [EW-1:0]           head;
    logic                    full;
    logic                    empty;
    logic                    pop;

    assign rxd_s    = sync_q[1];
    assign rxd_prev = sync_q[2];
    assign mid      = (cnt == (div_q >> 1));
    assign last     = (cnt == div_q);

    // Two-flop synchroniser plus one delayed copy; a start is only
    // taken on a high-to-low transition so a held-low break line
    // after a framing error does not retrigger the receiver.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[1:0], uart_rxd};
        end
    end

    // Frame receiver FSM: mid-bit sampling against a per-frame
    // latched divider, push request raised after the last stop sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            div_q    <= '0;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            ferr     <= 1'b0;
            push_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr     <= 1'b0;
`endif
        end else begin
            push_q <= 1'b0;
            cnt    <= cnt + 1'b1;
            unique case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rxd_s && rxd_prev) begin
                        state <= ST_START;
                        div_q <= divider;
                        ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr  <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (mid && rxd_s) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (last) begin
                        state   <= ST_DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (mid) begin
                        shreg <= {rxd_s, shreg[PAYLOAD_BITS-1:1]};
                    end
                    if (last) begin
                        cnt <= '0;
                        if (bit_idx == BW'(PAYLOAD_BITS-1)) begin
                            stop_idx <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            state    <= ST_PARITY;
`else
                            state    <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (mid) begin
                        perr <= (^shreg) ^ rxd_s ^ parity_odd;
                    end
                    if (last) begin
                        state    <= ST_STOP;
                        cnt      <= '0;
                        stop_idx <= 1'b0;
                    end
                end
`endif
                ST_STOP: begin
                    if (mid) begin
                        if (!rxd_s) begin
                            ferr <= 1'b1;
                        end
                        if (stop_idx == 1'(STOP_BITS-1)) begin
                            state  <= ST_IDLE;
                            cnt    <= '0;
                            push_q <= 1'b1;
                        end
                    end else if (last) begin
                        cnt      <= '0;
                        stop_idx <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    logic unused_parity;
    assign unused_parity = parity_odd;
    assign perr          = 1'b0;
`endif

    // Pack error flags at their fixed bit positions.
    always_comb begin
        flags              = '0;
        flags[ERR_FRAMING] = ferr;
        flags[ERR_PARITY]  = perr;
    end

    assign push_data = {flags, shreg};
    assign pop       = uart_rx_read && uart_rx_valid;

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    assign uart_rx_valid = !empty;
    assign uart_rx_data  = head[PAYLOAD_BITS-1:0];
    assign uart_rx_error = head[EW-1:PAYLOAD_BITS];

    // Sticky overrun: a dropped frame wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_rx_overrun <= 1'b0;
        end else if (push_q && full && !pop) begin
            uart_rx_overrun <= 1'b1;
        end else if (overrun_clear) begin
            uart_rx_overrun <= 1'b0;
        end
    end

    // Flow control: throttle the sender once one slot remains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_rts <= 1'b1;
        end else begin
            uart_rts <= (fifo_level >= LW'(FIFO_DEPTH-1));
        end
    end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered (8 data bits, 1 stop,
// 4-entry FIFO, divider 15). Parity cases follow UART_RX_PARITY_EN.
module tb_uart_rx_buffered;
    import uart_pkg::*;

    localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rxd;
    logic [15:0] divider;
    logic        parity_odd;
    logic        uart_rts;
    logic        uart_rx_read;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic [1:0]  uart_rx_error;
    logic        uart_rx_overrun;
    logic        overrun_clear;
    logic [2:0]  fifo_level;

    uart_rx_buffered #(
        .PAYLOAD_BITS (8),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (4),
        .DIV_W        (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .uart_rxd        (uart_rxd),
        .divider         (divider),
        .parity_odd      (parity_odd),
        .uart_rts        (uart_rts),
        .uart_rx_read    (uart_rx_read),
        .uart_rx_valid   (uart_rx_valid),
        .uart_rx_data    (uart_rx_data),
        .uart_rx_error   (uart_rx_error),
        .uart_rx_overrun (uart_rx_overrun),
        .overrun_clear   (overrun_clear),
        .fifo_level      (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] err;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_low;
        logic       bad_par;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic send_bit(input logic v);
        uart_rxd = v;
        repeat (BIT) @(negedge clk);
    endtask

    // Drive one frame and queue the record the receiver should hold.
    task automatic send_frame(input logic [7:0] d, input logic stop_low,
                              input logic bad_par, input bit expect_push);
        exp_t e;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
        if (PAR_EN) begin
            send_bit((^d) ^ parity_odd ^ bad_par);
        end
        send_bit(!stop_low);
        send_bit(1'b1);
        if (expect_push) begin
            e.data = d;
            e.err  = {PAR_EN & bad_par, stop_low};
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!uart_rx_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!uart_rx_valid) begin
            checks++;
            $display("FAIL wait_valid: valid=0 after %0d cycles, required 1",
                     budget);
        end
    endtask

    // Pop n entries, comparing each against the scoreboard.
    task automatic drain(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            wait_valid(400);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL scoreboard: entry %0h with no expectation",
                         uart_rx_data);
            end else begin
                e = exp_q.pop_front();
                chk("rx_data", 32'(uart_rx_data), 32'(e.data));
                chk("rx_error", 32'(uart_rx_error), 32'(e.err));
            end
            uart_rx_read = 1'b1;
            @(negedge clk);
            uart_rx_read = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, stop_low: 1'b0, bad_par: 1'b0};
        vecs[1] = '{data: 8'h00, stop_low: 1'b1, bad_par: 1'b0};
        vecs[2] = '{data: 8'h3C, stop_low: 1'b0, bad_par: 1'b0};
        vecs[3] = '{data: 8'hFF, stop_low: 1'b0, bad_par: 1'b0};
        vecs[4] = '{data: 8'h80, stop_low: 1'b0, bad_par: 1'b0};
        vecs[5] = '{data: 8'h01, stop_low: 1'b0, bad_par: 1'b1};

        reset         = 1'b1;
        uart_rxd      = 1'b1;
        divider       = 16'd15;
        parity_odd    = 1'b1;
        uart_rx_read  = 1'b0;
        overrun_clear = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_rts", 32'(uart_rts), 32'd1);
        chk("reset_valid", 32'(uart_rx_valid), 32'd0);
        chk("reset_data", 32'(uart_rx_data), 32'd0);
        chk("reset_error", 32'(uart_rx_error), 32'd0);
        chk("reset_overrun", 32'(uart_rx_overrun), 32'd0);
        chk("reset_level", 32'(fifo_level), 32'd0);

        reset = 1'b0;
        repeat (BIT) @(negedge clk);
        chk("idle_rts", 32'(uart_rts), 32'd0);

        // Single frames from the vector table, one at a time.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_low, vecs[i].bad_par, 1'b1);
            chk("vec_level", 32'(fifo_level), 32'd1);
            drain(1);
            chk("vec_empty", 32'(uart_rx_valid), 32'd0);
        end

        // Framing error followed directly by a good frame.
        send_frame(8'h00, 1'b1, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        chk("resync_level", 32'(fifo_level), 32'd2);
        drain(2);

        // Short low glitch must not produce a frame.
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("glitch_valid", 32'(uart_rx_valid), 32'd0);
        chk("glitch_level", 32'(fifo_level), 32'd0);
        chk("glitch_state", 32'(dut.state), 32'(ST_IDLE));

        // Fill past capacity with no reads.
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        chk("rts_at_2", 32'(uart_rts), 32'd0);
        send_frame(8'h33, 1'b0, 1'b0, 1'b1);
        chk("rts_at_3", 32'(uart_rts), 32'd1);
        send_frame(8'h44, 1'b0, 1'b0, 1'b1);
        chk("overrun_before", 32'(uart_rx_overrun), 32'd0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_overrun", 32'(uart_rx_overrun), 32'd1);
        chk("full_head", 32'(uart_rx_data), 32'h11);
        chk("full_rts", 32'(uart_rts), 32'd1);
        drain(4);
        chk("drained_level", 32'(fifo_level), 32'd0);
        chk("overrun_sticky", 32'(uart_rx_overrun), 32'd1);
        overrun_clear = 1'b1;
        @(negedge clk);
        overrun_clear = 1'b0;
        chk("overrun_cleared", 32'(uart_rx_overrun), 32'd0);

        // Reset in the middle of a data phase.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("mid_state", 32'(dut.state), 32'(ST_DATA));
        reset    = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_reset_level", 32'(fifo_level), 32'd0);
        chk("mid_reset_state", 32'(dut.state), 32'(ST_IDLE));
        reset = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        chk("mid_no_push", 32'(uart_rx_valid), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        drain(1);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffered.md
UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1..2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive buffer entries (power of 2, >=2).
REQ-004 SHALL have parameter DIV_W, default 16, width of the divider port.
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port uart_rxd, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port divider, input, DIV_W, clock cycles per bit minus 1 (legal >=3).
REQ-009 SHALL have port parity_odd, input, 1, 1 = odd parity, 0 = even; ignored without UART_RX_PARITY_EN.
REQ-010 SHALL have port uart_rts, output, 1, active-low request to send.
REQ-011 SHALL have port uart_rx_read, input, 1, pop head entry.
REQ-012 SHALL have port uart_rx_valid, output, 1, FIFO non-empty.
REQ-013 SHALL have port uart_rx_data, output, PAYLOAD_BITS, head entry data.
REQ-014 SHALL have port uart_rx_error, output, 2, head entry flags {parity, framing}.
REQ-015 SHALL have port uart_rx_overrun, output, 1, sticky: frame dropped on full FIFO.
REQ-016 SHALL have port overrun_clear, input, 1, clears uart_rx_overrun.
REQ-017 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1, entries held.

Function
REQ-018 SHALL pass uart_rxd through a 2-flop synchroniser; all timing below is relative to the synchronised signal.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP; IDLE->START on synchronised low.
REQ-020 SHALL latch divider on IDLE->START and use the latched value for the whole frame.
REQ-021 SHALL sample at bit counter == latched_divider>>1 (mid-bit), advance bit at counter == latched_divider.
REQ-022 SHALL return START->IDLE with no push if the line is high at the start-bit mid-sample (glitch rejection).
REQ-023 SHALL shift data LSB first, PAYLOAD_BITS bits, then PARITY (macro only), then STOP.
REQ-024 SHALL set the framing flag if any stop-bit mid-sample is low; the frame SHALL still be pushed.
REQ-025 SHALL go STOP->IDLE at the mid-sample of the last stop bit and push the frame on the next cycle.
REQ-026 SHALL present head entry combinationally from FIFO storage; pop on uart_rx_read && uart_rx_valid; read when empty ignored.
REQ-027 SHALL, on push to a full FIFO without same-cycle pop, drop the new frame, keep contents, set uart_rx_overrun.
REQ-028 SHALL accept push and pop in the same cycle at any level, including full; level unchanged.
REQ-029 SHALL give set priority over overrun_clear when both occur in one cycle.
REQ-030 SHALL register uart_rts: 1 when fifo_level >= FIFO_DEPTH-1, else 0.
REQ-031 SHALL wrap FIFO pointers modulo FIFO_DEPTH with an extra bit distinguishing full from empty.

Reset
REQ-032 SHALL on reset: state IDLE, uart_rts=1, uart_rx_valid=0, uart_rx_data=0, uart_rx_error=0, uart_rx_overrun=0, fifo_level=0, synchroniser=1.
REQ-033 SHALL discard any partial frame and flush the FIFO when reset asserts mid-frame.

Configuration
REQ-034 SHALL, with UART_RX_PARITY_EN defined, receive one parity bit after data and set the parity flag on mismatch per parity_odd.
REQ-035 SHALL, without UART_RX_PARITY_EN, have no PARITY state, parity flag tied 0, parity_odd unused.

Structure
REQ-036 SHALL place FSM state encoding and error-flag bit indices in shared package uart_pkg.
REQ-037 SHALL implement the buffer as sub-module uart_rx_fifo (sync FIFO, data+flags width).

Verification
REQ-038 divider=15, 8N1, send 0xA5 -> one push, uart_rx_data=0xA5, uart_rx_error=00, fifo_level=1.
REQ-039 divider=15, rxd low 4 cycles then high -> no push, state IDLE, fifo_level=0.
REQ-040 send 0x00 with stop bit low -> entry data 0x00, uart_rx_error=01, receiver resynchronises to next frame 0x3C.
REQ-041 FIFO_DEPTH=4, send 0x11..0x55 no reads -> uart_rts=1 after third push, level 4, overrun=1, head 0x11; reads return 0x11..0x44.
REQ-042 UART_RX_PARITY_EN, parity_odd=1, send 0x01 with parity bit 1 -> uart_rx_error=10.
REQ-043 reset asserted during DATA of 0x5A -> FIFO empty, no push, next frame 0x5A received correctly.
